axi_sram_slave: RTL and testbench

AXI4 responder that terminates one slave port of the AXI interconnect (S0/S1 side) and drives a single-port synchronous SRAM macro. It accepts one read or write burst at a time, sequences SRAM accesses beat by beat, and returns R or B responses carrying the slave-side ID it received.

---
 rtl/axi_sram_slave.sv | 198 +++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// AXI4 slave port terminating into a single-port synchronous SRAM macro.
// Handles one INCR burst at a time and returns R/B with the captured ID.
module axi_sram_slave #(
    parameter  int unsigned MEM_AW = 14,
    localparam int unsigned IDS_W  = 8,
    localparam int unsigned ADDR_W = 32,
    localparam int unsigned LEN_W  = 4,
    localparam int unsigned SIZE_W = 3,
    localparam int unsigned DATA_W = 32,
    localparam int unsigned STRB_W = 4
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [IDS_W-1:0]  AWID,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic [LEN_W-1:0]  AWLEN,
    input  logic [SIZE_W-1:0] AWSIZE,
    input  logic [1:0]        AWBURST,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [STRB_W-1:0] WSTRB,
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [IDS_W-1:0]  BID,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [IDS_W-1:0]  ARID,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [LEN_W-1:0]  ARLEN,
    input  logic [SIZE_W-1:0] ARSIZE,
    input  logic [1:0]        ARBURST,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [IDS_W-1:0]  RID,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    output logic              CEB,
    output logic              WEB,
    output logic [DATA_W-1:0] BWEB,
    output logic [MEM_AW-1:0] A,
    output logic [DATA_W-1:0] DI,
    input  logic [DATA_W-1:0] DO
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RFETCH,
        S_RDATA,
        S_WDATA,
        S_WRESP
    } state_e;

    state_e state_q, state_d;

    logic [IDS_W-1:0]  id_q;
    logic [MEM_AW-1:0] addr_q;
    logic [MEM_AW-1:0] addr_inc;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_q;
    logic              err_q;

    logic last_beat;
    logic aw_hs, ar_hs, w_hs, r_hs, b_hs;

    // Burst type, size and sub-word address bits are not used by this slave.
    logic unused_inputs;
    assign unused_inputs = ^{AWSIZE, AWBURST, ARSIZE, ARBURST,
                             AWADDR[ADDR_W-1:MEM_AW+2], AWADDR[1:0],
                             ARADDR[ADDR_W-1:MEM_AW+2], ARADDR[1:0]};

    assign last_beat = (beat_q == len_q);
    assign addr_inc  = addr_q + MEM_AW'(1);

    // Write has priority over read when both address channels are valid.
    assign aw_hs = (state_q == S_IDLE) && AWVALID;
    assign ar_hs = (state_q == S_IDLE) && ARVALID && !AWVALID;
    assign w_hs  = (state_q == S_WDATA) && WVALID;
    assign r_hs  = (state_q == S_RDATA) && RREADY;
    assign b_hs  = (state_q == S_WRESP) && BREADY;

    always_ff @(posedge ACLK) begin
        if (ARESET) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (AWVALID)      state_d = S_WDATA;
                else if (ARVALID) state_d = S_RFETCH;
            end
            S_RFETCH: state_d = S_RDATA;
            S_RDATA:  if (r_hs && last_beat) state_d = S_IDLE;
            S_WDATA:  if (w_hs && last_beat) state_d = S_WRESP;
            S_WRESP:  if (b_hs) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Burst context: ID, running word address, beat count and WLAST error flag.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            id_q   <= '0;
            addr_q <= '0;
            len_q  <= '0;
            beat_q <= '0;
            err_q  <= 1'b0;
        end else if (aw_hs) begin
            id_q   <= AWID;
            addr_q <= AWADDR[MEM_AW+1:2];
            len_q  <= AWLEN;
            beat_q <= '0;
            err_q  <= 1'b0;
        end else if (ar_hs) begin
            id_q   <= ARID;
            addr_q <= ARADDR[MEM_AW+1:2];
            len_q  <= ARLEN;
            beat_q <= '0;
            err_q  <= 1'b0;
        end else if (w_hs) begin
            addr_q <= addr_inc;
            beat_q <= beat_q + LEN_W'(1);
            err_q  <= err_q | (WLAST != last_beat);
        end else if (r_hs && !last_beat) begin
            addr_q <= addr_inc;
            beat_q <= beat_q + LEN_W'(1);
        end
    end

    // Channel and SRAM outputs; everything is forced idle while reset is high.
    always_comb begin
        AWREADY = 1'b0;
        ARREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        BID     = '0;
        BRESP   = 2'b00;
        RVALID  = 1'b0;
        RID     = '0;
        RDATA   = '0;
        RRESP   = 2'b00;
        RLAST   = 1'b0;
        CEB     = 1'b1;
        WEB     = 1'b1;
        BWEB    = '1;
        A       = '0;
        DI      = '0;
        if (!ARESET) begin
            case (state_q)
                S_IDLE: begin
                    AWREADY = 1'b1;
                    ARREADY = !AWVALID;
                end
                S_RFETCH: begin
                    CEB = 1'b0;
                    A   = addr_q;
                end
                S_RDATA: begin
                    RVALID = 1'b1;
                    RDATA  = DO;
                    RID    = id_q;
                    RLAST  = last_beat;
                    // Prefetch the next word so it lands on DO as this beat retires.
                    if (RREADY && !last_beat) begin
                        CEB = 1'b0;
                        A   = addr_inc;
                    end
                end
                S_WDATA: begin
                    WREADY = 1'b1;
                    if (WVALID) begin
                        CEB = 1'b0;
                        WEB = 1'b0;
                        A   = addr_q;
                        DI  = WDATA;
                        for (int i = 0; i < int'(STRB_W); i++) begin
                            BWEB[8*i +: 8] = {8{~WSTRB[i]}};
                        end
                    end
                end
                S_WRESP: begin
                    BVALID = 1'b1;
                    BID    = id_q;
                    BRESP  = err_q ? 2'b10 : 2'b00;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a behavioural SRAM model.
module tb_axi_sram_slave;

    localparam int unsigned MEM_AW = 14;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [7:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [7:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [7:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [7:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        CEB;
    logic        WEB;
    logic [31:0] BWEB;
    logic [MEM_AW-1:0] A;
    logic [31:0] DI;
    logic [31:0] DO;

    logic [31:0] mem [0:(1<<MEM_AW)-1];
    logic        pl_en;
    logic [MEM_AW-1:0] pl_addr;
    logic [31:0] pl_data;
    logic [31:0] rexp [0:3];

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    axi_sram_slave #(.MEM_AW(MEM_AW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY),
        .CEB(CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .DI(DI), .DO(DO)
    );

    // Single-port SRAM: masked write, registered read, DO held while disabled.
    always @(posedge ACLK) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (!CEB) begin
            if (!WEB) mem[A] <= (mem[A] & BWEB) | (DI & ~BWEB);
            else      DO <= mem[A];
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [MEM_AW-1:0] addr, input logic [31:0] data);
        pl_addr = addr;
        pl_data = data;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [31:0] d0, input logic [31:0] d1, input logic [3:0] strb,
                            input logic [31:0] exp_bweb, input logic last_ok,
                            input logic [1:0] exp_bresp);
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWBURST = 2'b01;
        AWVALID = 1'b1;
        #1;
        check("awready", 32'(AWREADY), 32'd1);
        check("arready_blocked_by_aw", 32'(ARREADY), 32'd0);
        tick();
        AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            WDATA  = (i == 0) ? d0 : d1;
            WSTRB  = strb;
            WLAST  = last_ok ? (i == int'(len)) : 1'b0;
            WVALID = 1'b1;
            #1;
            check("wready", 32'(WREADY), 32'd1);
            check("w_ceb", 32'(CEB), 32'd0);
            check("w_web", 32'(WEB), 32'd0);
            check("w_addr", 32'(A), 32'(MEM_AW'(addr[MEM_AW+1:2] + MEM_AW'(i))));
            check("w_di", DI, WDATA);
            check("w_bweb", BWEB, exp_bweb);
            tick();
        end
        WVALID = 1'b0;
        #1;
        check("wready_after_last", 32'(WREADY), 32'd0);
        check("bvalid", 32'(BVALID), 32'd1);
        check("bid", 32'(BID), 32'(id));
        check("bresp", 32'(BRESP), 32'(exp_bresp));
        tick();
        check("bvalid_hold", 32'(BVALID), 32'd1);
        check("bid_hold", 32'(BID), 32'(id));
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        #1;
        check("bvalid_drop", 32'(BVALID), 32'd0);
    endtask

    task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic stall);
        int beats = 0;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARBURST = 2'b00;
        ARVALID = 1'b1;
        #1;
        check("arready", 32'(ARREADY), 32'd1);
        tick();
        ARVALID = 1'b0;
        #1;
        check("rfetch_ceb", 32'(CEB), 32'd0);
        check("rfetch_web", 32'(WEB), 32'd1);
        check("rfetch_addr", 32'(A), 32'(addr[MEM_AW+1:2]));
        check("rfetch_rvalid", 32'(RVALID), 32'd0);
        tick();
        for (int c = 0; c < 40 && beats <= int'(len); c++) begin
            RREADY = stall ? c[0] : 1'b1;
            #1;
            check("rvalid", 32'(RVALID), 32'd1);
            check("rdata", RDATA, rexp[beats]);
            check("rid", 32'(RID), 32'(id));
            check("rlast", 32'(RLAST), 32'(beats == int'(len)));
            check("rresp", 32'(RRESP), 32'd0);
            if (RREADY) beats++;
            tick();
        end
        RREADY = 1'b0;
        check("beat_count", 32'(beats), 32'(len) + 32'd1);
        #1;
        check("rvalid_drop", 32'(RVALID), 32'd0);
        tick();
        check("rvalid_stays_low", 32'(RVALID), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ARESET = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
        RREADY = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        tick();
        tick();
        check("rst_awready", 32'(AWREADY), 32'd0);
        check("rst_arready", 32'(ARREADY), 32'd0);
        check("rst_rvalid", 32'(RVALID), 32'd0);
        check("rst_bvalid", 32'(BVALID), 32'd0);
        check("rst_ceb", 32'(CEB), 32'd1);
        check("rst_web", 32'(WEB), 32'd1);
        check("rst_bweb", BWEB, 32'hFFFF_FFFF);
        check("rst_a", 32'(A), 32'd0);

        preload(14'h10, 32'hDEAD_BEEF);
        preload(14'h0, 32'hA0);
        preload(14'h1, 32'hA1);
        preload(14'h2, 32'hA2);
        preload(14'h3, 32'hA3);
        preload(14'h5, 32'hFFFF_FFFF);
        preload(14'h30, 32'hB0);
        preload(14'h31, 32'hB1);
        preload(14'h32, 32'hB2);
        preload(14'h33, 32'hB3);
        ARESET = 1'b0;
        tick();

        // Single-beat read
        rexp[0] = 32'hDEAD_BEEF;
        do_read(8'h25, 32'h40, 4'd0, 1'b0);

        // Four-beat read with RREADY toggling
        rexp[0] = 32'hA0; rexp[1] = 32'hA1; rexp[2] = 32'hA2; rexp[3] = 32'hA3;
        do_read(8'h31, 32'h0, 4'd3, 1'b1);

        // Strobed single-beat write
        do_write(8'h3C, 32'h14, 4'd0, 32'h1234_5678, 32'h0, 4'b0011, 32'hFFFF_0000, 1'b1, 2'b00);
        check("mem_word5", mem[5], 32'hFFFF_5678);

        // AW and AR together: write first, then the read sees the new data
        ARID = 8'h22; ARADDR = 32'h80; ARLEN = 4'd0; ARVALID = 1'b1;
        do_write(8'h11, 32'h80, 4'd0, 32'hCAFE_F00D, 32'h0, 4'hF, 32'h0, 1'b1, 2'b00);
        check("pending_arready", 32'(ARREADY), 32'd1);
        rexp[0] = 32'hCAFE_F00D;
        do_read(8'h22, 32'h80, 4'd0, 1'b0);

        // Address wrap with WLAST never asserted
        do_write(8'h5A, 32'h0000_FFFC, 4'd1, 32'h1111_1111, 32'h2222_2222, 4'hF, 32'h0, 1'b0, 2'b10);
        check("mem_last_word", mem[(1<<MEM_AW)-1], 32'h1111_1111);
        check("mem_word0_wrap", mem[0], 32'h2222_2222);

        // Reset while beat 2 of a four-beat read is presented
        ARID = 8'h44; ARADDR = 32'hC0; ARLEN = 4'd3; ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        tick();
        RREADY = 1'b1;
        tick();
        tick();
        check("pre_reset_rdata", RDATA, 32'hB2);
        check("pre_reset_rvalid", 32'(RVALID), 32'd1);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        RREADY = 1'b0;
        #1;
        check("post_reset_rvalid", 32'(RVALID), 32'd0);
        check("post_reset_bvalid", 32'(BVALID), 32'd0);
        check("post_reset_ceb", 32'(CEB), 32'd1);
        check("post_reset_arready", 32'(ARREADY), 32'd1);
        RREADY = 1'b1;
        tick();
        check("no_beat_after_reset", 32'(RVALID), 32'd0);
        tick();
        check("no_beat_after_reset2", 32'(RVALID), 32'd0);
        RREADY = 1'b0;

        rexp[0] = 32'hB0; rexp[1] = 32'hB1; rexp[2] = 32'hB2; rexp[3] = 32'hB3;
        do_read(8'h45, 32'hC0, 4'd3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
